uart_host_frame_initiator: RTL and testbench
============================================

Name: uart_host_frame_initiator

Overview:
Host-side counterpart of the UART-AXI4 bridge: accepts one register read/write command, serializes it as a host-to-device frame, then parses and CRC-checks the device-to-host response and returns the status and read data. Sits between a command source (self-test sequencer or loopback harness) and a UART TX/RX byte-level core, so the bridge can be exercised in hardware without an external host.

Parameters:
TIMEOUT_CYCLES, 250000, max idle clk cycles waiting for any response byte (2 ms at 125 MHz); reloaded on every accepted rx byte
TO_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1 = write (CMD 0x20), 0 = read (CMD 0x10)
cmd_addr  in  32  register address
cmd_wdata  in  32  write data (ignored for reads)
tx_data  out  8  byte to UART TX core
tx_valid  out  1  byte valid
tx_ready  in  1  UART TX core accepts byte
rx_data  in  8  byte from UART RX core
rx_valid  in  1  single-cycle byte strobe, no backpressure
rsp_valid  out  1  one-cycle result pulse
rsp_status  out  8  STATUS byte from device (0x00 = OK)
rsp_rdata  out  32  read data, little-endian reassembled
rsp_err  out  3  0 none, 1 timeout, 2 CRC mismatch, 3 CMD echo mismatch
busy  out  1  high outside IDLE
drop_count  out  16  rx bytes discarded (outside a frame or before SOF); saturates at 0xFFFF

Behaviour:
- Reset: all outputs 0; cmd_ready is 1 one cycle after rst_n deasserts. An async reset mid-frame aborts with no rsp_valid.
- Request frame: A5, CMD, ADDR[7:0]..ADDR[31:24], then for writes DATA[7:0]..DATA[31:24], then CRC8. Writes are 11 bytes, reads 7.
- CRC8 uses pkg crc8_update: poly 0x07, init 0x00, over CMD through the last ADDR/DATA byte. SOF is excluded.
- Command handshake: accepted on cmd_valid && cmd_ready. Fields are latched that cycle; the first tx_valid appears the next cycle.
- TX handshake: a byte transfers on tx_valid && tx_ready. tx_data is held stable while tx_valid && !tx_ready, and tx_valid never drops without a transfer.
- FSM states: IDLE, TX_FRAME, WAIT_SOF, RX_STATUS, RX_CMD, RX_DATA, RX_CRC, DONE.
  - IDLE -> TX_FRAME on accept.
  - TX_FRAME -> WAIT_SOF after the CRC byte transfers. The timeout counter loads TIMEOUT_CYCLES here.
  - WAIT_SOF: rx byte 0x5A -> RX_STATUS. Any other byte is dropped and drop_count increments.
  - RX_STATUS -> RX_CMD.
  - RX_CMD -> RX_DATA if (read && status==0x00), else RX_CRC.
  - RX_DATA: 4 bytes, then RX_CRC.
  - RX_CRC -> DONE.
  - DONE: rsp_valid=1 for exactly 1 cycle, then IDLE.
- Response CRC: crc8 over STATUS, CMD echo and any DATA bytes, compared with the received CRC byte.
- Error priority: timeout > CRC > echo. Timeout has no CRC/echo check; rsp_status=0xFF and rsp_rdata=0.
- On a CRC or echo error, rsp_status and rsp_rdata still carry the received values.
- Timeout counter runs in WAIT_SOF..RX_CRC. It reloads on each rx_valid; on reaching 0 the FSM goes to DONE with rsp_err=1.
- rx_valid in IDLE or TX_FRAME: byte dropped, drop_count increments, state unchanged.
- rx_valid coinciding with the timeout-expiry cycle: the byte is accepted and the counter reloads (the byte wins).
- rsp_* registers hold their values until the next DONE.

Decomposition:
- Shared package uart_frame_pkg holds:
  - SOF_H2D=8'hA5, SOF_D2H=8'h5A
  - CMD_READ=8'h10, CMD_WRITE=8'h20
  - STATUS_OK=8'h00
  - err_e enum
  - crc8_update function, shared with the bridge parser/builder so the CRC definition is not duplicated.
- One sub-module, uart_frame_crc8: running-CRC register with clear and byte-enable. It is instantiated twice, once for TX and once for RX.

Test Plan:
- Write 0x1020 / 0xDEADBEEF with tx_ready always 1 -> tx stream is A5 20 20 10 00 00 EF BE AD DE <golden crc8>. Reply 5A 00 20 <crc> -> rsp_valid once, status 0x00, err 0.
- Read 0x1020, reply 5A 00 10 EF BE AD DE <crc> -> rsp_rdata=0xDEADBEEF, err 0. Same read with the reply CRC byte inverted -> err 2, rdata still 0xDEADBEEF.
- Random tx_ready stalls (50%) on a write -> byte order and values unchanged, tx_data stable during stalls, no duplicated bytes.
- Read, reply 5A 00 20 <valid crc> -> err 3. Reply 5A 01 10 <crc> (no data) -> status 0x01, err 0, frame ends after 4 bytes.
- Read with no reply, TIMEOUT_CYCLES=100 -> rsp_valid exactly 100 cycles after the last tx transfer, err 1, status 0xFF. Then 3 stray bytes arrive in IDLE -> drop_count=3.
- Garbage 0x11 0x22 before 5A in WAIT_SOF -> drop_count increments by 2, response parsed correctly. rst_n pulsed during RX_DATA -> no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared constants, error codes and CRC8 step for the UART host/device frame format.
// Used by the frame initiator and the bridge parser/builder alike.
package uart_frame_pkg;

  localparam logic [7:0] SOF_H2D   = 8'hA5;
  localparam logic [7:0] SOF_D2H   = 8'h5A;
  localparam logic [7:0] CMD_READ  = 8'h10;
  localparam logic [7:0] CMD_WRITE = 8'h20;
  localparam logic [7:0] STATUS_OK = 8'h00;

  typedef enum logic [2:0] {
    ErrNone    = 3'd0,
    ErrTimeout = 3'd1,
    ErrCrc     = 3'd2,
    ErrEcho    = 3'd3
  } err_e;

  // One byte of CRC-8, polynomial 0x07, MSB first.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_frame_crc8.sv
// Running CRC-8 register: clear takes priority over a byte update.
module uart_frame_crc8
  import uart_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  logic [7:0] crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 8'h00;
    end else if (clear) begin
      crc_q <= 8'h00;
    end else if (en) begin
      crc_q <= crc8_update(crc_q, data);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/uart_host_frame_initiator.sv
// Host-side frame initiator: sends one read/write request frame over a byte stream,
// then parses and CRC-checks the device response and reports status, data and error.
module uart_host_frame_initiator
  import uart_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 250000,
  parameter int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [7:0]  rsp_status,
  output logic [31:0] rsp_rdata,
  output logic [2:0]  rsp_err,
  output logic        busy,
  output logic [15:0] drop_count
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StTxFrame  = 3'd1;
  localparam logic [2:0] StWaitSof  = 3'd2;
  localparam logic [2:0] StRxStatus = 3'd3;
  localparam logic [2:0] StRxCmd    = 3'd4;
  localparam logic [2:0] StRxData   = 3'd5;
  localparam logic [2:0] StRxCrc    = 3'd6;
  localparam logic [2:0] StDone     = 3'd7;

  logic [2:0]      state_q, state_d;
  logic            init_q;
  logic            write_q;
  logic [31:0]     addr_q, wdata_q;
  logic [3:0]      tx_idx_q;
  logic [TO_W-1:0] to_q;
  logic [1:0]      rx_cnt_q;
  logic [7:0]      status_q, echo_q;
  logic [31:0]     rdata_q;
  logic [7:0]      rsp_status_q;
  logic [31:0]     rsp_rdata_q;
  err_e            rsp_err_q, rx_err;
  logic [15:0]     drop_q;

  logic       accept, tx_fire, tx_done, rx_in_frame, timeout_hit, drop_byte;
  logic [3:0] tx_last;
  logic [7:0] cmd_byte, tx_crc, rx_crc;
  logic       tx_crc_en, rx_crc_en;

  assign cmd_ready   = init_q && (state_q == StIdle);
  assign accept      = cmd_valid && cmd_ready;
  assign tx_valid    = (state_q == StTxFrame);
  assign tx_fire     = tx_valid && tx_ready;
  assign tx_last     = write_q ? 4'd10 : 4'd6;
  assign tx_done     = tx_fire && (tx_idx_q == tx_last);
  assign cmd_byte    = write_q ? CMD_WRITE : CMD_READ;
  assign rx_in_frame = state_q inside {StWaitSof, StRxStatus, StRxCmd, StRxData, StRxCrc};
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout_hit = rx_in_frame && !rx_valid && (to_q <= TO_W'(1));
  assign drop_byte   = rx_valid && ((state_q inside {StIdle, StTxFrame, StDone}) ||
                                    ((state_q == StWaitSof) && (rx_data != SOF_D2H)));

  // SOF and the trailing CRC byte are excluded from the request CRC.
  assign tx_crc_en = tx_fire && (tx_idx_q != 4'd0) && (tx_idx_q != tx_last);
  assign rx_crc_en = rx_valid && (state_q inside {StRxStatus, StRxCmd, StRxData});

  uart_frame_crc8 u_tx_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q == StIdle),
    .en    (tx_crc_en),
    .data  (tx_data),
    .crc   (tx_crc)
  );

  uart_frame_crc8 u_rx_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q == StWaitSof),
    .en    (rx_crc_en),
    .data  (rx_data),
    .crc   (rx_crc)
  );

  always_comb begin
    tx_data = 8'h00;
    if (state_q == StTxFrame) begin
      case (tx_idx_q)
        4'd0:    tx_data = SOF_H2D;
        4'd1:    tx_data = cmd_byte;
        4'd2:    tx_data = addr_q[7:0];
        4'd3:    tx_data = addr_q[15:8];
        4'd4:    tx_data = addr_q[23:16];
        4'd5:    tx_data = addr_q[31:24];
        4'd6:    tx_data = wdata_q[7:0];
        4'd7:    tx_data = wdata_q[15:8];
        4'd8:    tx_data = wdata_q[23:16];
        4'd9:    tx_data = wdata_q[31:24];
        default: tx_data = 8'h00;
      endcase
      if (tx_idx_q == tx_last) begin
        tx_data = tx_crc;
      end
    end
  end

  always_comb begin
    rx_err = ErrNone;
    if (rx_crc != rx_data) begin
      rx_err = ErrCrc;
    end else if (echo_q != cmd_byte) begin
      rx_err = ErrEcho;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (accept) state_d = StTxFrame;
      StTxFrame:  if (tx_done) state_d = StWaitSof;
      StWaitSof:  if (rx_valid && (rx_data == SOF_D2H)) state_d = StRxStatus;
      StRxStatus: if (rx_valid) state_d = StRxCmd;
      StRxCmd: begin
        if (rx_valid) begin
          state_d = ((rx_data == CMD_READ) && (status_q == STATUS_OK)) ? StRxData : StRxCrc;
        end
      end
      StRxData:   if (rx_valid && (rx_cnt_q == 2'd3)) state_d = StRxCrc;
      StRxCrc:    if (rx_valid) state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    if (timeout_hit) begin
      state_d = StDone;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      init_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      tx_idx_q     <= '0;
      to_q         <= '0;
      rx_cnt_q     <= '0;
      status_q     <= '0;
      echo_q       <= '0;
      rdata_q      <= '0;
      rsp_status_q <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= ErrNone;
      drop_q       <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;

      if (accept) begin
        write_q  <= cmd_write;
        addr_q   <= cmd_addr;
        wdata_q  <= cmd_wdata;
        tx_idx_q <= '0;
      end else if (tx_fire) begin
        tx_idx_q <= tx_idx_q + 4'd1;
      end

      if (tx_done) begin
        to_q <= TO_W'(TIMEOUT_CYCLES);
      end else if (rx_in_frame) begin
        if (rx_valid) begin
          to_q <= TO_W'(TIMEOUT_CYCLES);
        end else if (to_q != '0) begin
          to_q <= to_q - TO_W'(1);
        end
      end

      if (state_q == StWaitSof) begin
        rx_cnt_q <= '0;
        rdata_q  <= '0;
      end
      if (rx_valid) begin
        if (state_q == StRxStatus) status_q <= rx_data;
        if (state_q == StRxCmd) echo_q <= rx_data;
        if (state_q == StRxData) begin
          rdata_q  <= {rx_data, rdata_q[31:8]};
          rx_cnt_q <= rx_cnt_q + 2'd1;
        end
      end

      if (timeout_hit) begin
        rsp_status_q <= 8'hFF;
        rsp_rdata_q  <= '0;
        rsp_err_q    <= ErrTimeout;
      end else if ((state_q == StRxCrc) && rx_valid) begin
        rsp_status_q <= status_q;
        rsp_rdata_q  <= rdata_q;
        rsp_err_q    <= rx_err;
      end

      if (drop_byte && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign rsp_valid  = (state_q == StDone);
  assign rsp_status = rsp_status_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != StIdle);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_uart_host_frame_initiator.sv
// Self-checking bench: directed and randomized request/response frames against a
// byte-queue reference model with an independent augmented-division CRC.
module tb_uart_host_frame_initiator;

  typedef logic [7:0] bq_t[$];
  localparam int unsigned TO = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rsp_valid;
  logic [7:0]  rsp_status;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_err;
  logic        busy;
  logic [15:0] drop_count;

  uart_host_frame_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rsp_valid  (rsp_valid),
    .rsp_status (rsp_status),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Monitor state, sampled 2 time units after each falling edge.
  bq_t         txq;
  longint      last_tx_t, rsp_t;
  int          rsp_cnt = 0;
  int          stab_err = 0;
  logic        stall_pend = 1'b0;
  logic [7:0]  stall_data;
  logic [7:0]  cap_status;
  logic [31:0] cap_rdata;
  logic [2:0]  cap_err;

  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend && !(tx_valid === 1'b1 && tx_data === stall_data)) stab_err++;
      stall_pend = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (tx_valid && tx_ready) begin
        txq.push_back(tx_data);
        last_tx_t = $time + 3;  // the rising edge that performs the transfer
      end
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_t      = $time - 7;  // the rising edge that raised rsp_valid
        cap_status = rsp_status;
        cap_rdata  = rsp_rdata;
        cap_err    = rsp_err;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // CRC as remainder of (message * x^8) mod (x^8 + x^2 + x + 1).
  function automatic logic [7:0] ref_crc(input bq_t msg);
    logic [8:0] rem;
    rem = '0;
    for (int i = 0; i < msg.size() + 1; i++) begin
      for (int b = 7; b >= 0; b--) begin
        rem = {rem[7:0], (i < msg.size()) ? msg[i][b] : 1'b0};
        if (rem[8]) rem = rem ^ 9'h107;
      end
    end
    return rem[7:0];
  endfunction

  task automatic build_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           output bq_t q);
    bq_t body;
    body.push_back(wr ? 8'h20 : 8'h10);
    for (int i = 0; i < 4; i++) body.push_back(a[8*i +: 8]);
    if (wr) for (int i = 0; i < 4; i++) body.push_back(d[8*i +: 8]);
    q = body;
    q.push_front(8'hA5);
    q.push_back(ref_crc(body));
  endtask

  task automatic make_reply(input logic [7:0] st, input logic [7:0] echo, input bit with_data,
                            input logic [31:0] d, input bit corrupt, output bq_t q);
    bq_t body;
    body.push_back(st);
    body.push_back(echo);
    if (with_data) for (int i = 0; i < 4; i++) body.push_back(d[8*i +: 8]);
    q = body;
    q.push_front(8'h5A);
    q.push_back(ref_crc(body) ^ (corrupt ? 8'hFF : 8'h00));
  endtask

  task automatic send_bytes(input bq_t q);
    foreach (q[i]) begin
      rx_valid = 1'b1;
      rx_data  = q[i];
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic do_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit stall);
    bq_t exp;
    int  cyc;
    build_req(wr, a, d, exp);
    txq.delete();
    cyc = 0;
    while (cmd_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    tx_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    chk("tx_valid_after_accept", tx_valid, 1);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);  // fields must already be latched
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cyc = 0;
    while (txq.size() < exp.size() && cyc < 400) begin
      tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("tx_frame_len", txq.size(), exp.size());
    foreach (exp[i]) chk($sformatf("tx_byte%0d", i), txq[i], exp[i]);
    chk("busy_wait_rsp", busy, 1);
  endtask

  task automatic do_reply(input bit wr, input bq_t rb);
    int          c0, cyc, nd;
    logic [7:0]  st, echo, crc_rx;
    logic [31:0] rd;
    logic [2:0]  err;
    bq_t         body;
    c0 = rsp_cnt;
    send_bytes(rb);
    cyc = 0;
    while (rsp_cnt == c0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    chk("rsp_pulse_count", rsp_cnt, c0 + 1);
    // Response rules: data follows only for a read echo with OK status.
    st   = rb[1];
    echo = rb[2];
    nd   = (echo == 8'h10 && st == 8'h00) ? 4 : 0;
    rd   = '0;
    for (int i = 0; i < nd; i++) rd[8*i +: 8] = rb[3+i];
    for (int i = 1; i < 3 + nd; i++) body.push_back(rb[i]);
    crc_rx = rb[3+nd];
    if (ref_crc(body) != crc_rx) err = 3'd2;
    else if (echo != (wr ? 8'h20 : 8'h10)) err = 3'd3;
    else err = 3'd0;
    chk("rsp_status", cap_status, st);
    chk("rsp_rdata", cap_rdata, rd);
    chk("rsp_err", cap_err, err);
    chk("cmd_ready_after_rsp", cmd_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t         rb;
    logic [7:0]  golden [10];
    int          c0, cyc;
    logic [15:0] d0;
    bit          wr, corrupt;
    logic [31:0] a, d;
    logic [7:0]  st, echo;

    golden = '{8'hA5, 8'h20, 8'h20, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    tx_ready = 1'b1; rx_valid = 1'b0; rx_data = '0;

    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_drop", drop_count, 0);
    chk("reset_rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    #1;
    chk("release_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    chk("cmd_ready_1cyc", cmd_ready, 1);

    // Directed write with the known byte stream.
    do_cmd(1'b1, 32'h0000_1020, 32'hDEAD_BEEF, 1'b0);
    foreach (golden[i]) chk($sformatf("golden_byte%0d", i), txq[i], golden[i]);
    make_reply(8'h00, 8'h20, 1'b0, '0, 1'b0, rb);
    do_reply(1'b1, rb);

    // Read with data, then the same read with the reply CRC inverted.
    do_cmd(1'b0, 32'h0000_1020, '0, 1'b0);
    make_reply(8'h00, 8'h10, 1'b1, 32'hDEAD_BEEF, 1'b0, rb);
    do_reply(1'b0, rb);
    chk("read_rdata_lit", cap_rdata, 32'hDEAD_BEEF);
    do_cmd(1'b0, 32'h0000_1020, '0, 1'b0);
    make_reply(8'h00, 8'h10, 1'b1, 32'hDEAD_BEEF, 1'b1, rb);
    do_reply(1'b0, rb);
    chk("crc_err_lit", cap_err, 2);

    // Write under random tx_ready stalls.
    do_cmd(1'b1, $urandom, $urandom, 1'b1);
    make_reply(8'h00, 8'h20, 1'b0, '0, 1'b0, rb);
    do_reply(1'b1, rb);

    // Echo mismatch, then non-OK status without data.
    do_cmd(1'b0, 32'h0000_1020, '0, 1'b0);
    make_reply(8'h00, 8'h20, 1'b0, '0, 1'b0, rb);
    do_reply(1'b0, rb);
    chk("echo_err_lit", cap_err, 3);
    do_cmd(1'b0, 32'h0000_1020, '0, 1'b0);
    make_reply(8'h01, 8'h10, 1'b0, '0, 1'b0, rb);
    do_reply(1'b0, rb);
    chk("status01_lit", cap_status, 8'h01);

    // Read with no reply: timeout.
    do_cmd(1'b0, $urandom, '0, 1'b0);
    c0  = rsp_cnt;
    cyc = 0;
    while (rsp_cnt == c0 && cyc < 3 * TO) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    chk("timeout_pulse_count", rsp_cnt, c0 + 1);
    chk("timeout_latency", 32'(rsp_t - last_tx_t), TO * 10);
    chk("timeout_err", cap_err, 1);
    chk("timeout_status", cap_status, 8'hFF);
    chk("timeout_rdata", cap_rdata, 0);

    // Stray bytes while idle.
    d0 = drop_count;
    rb = '{8'h5A, 8'h33, 8'h44};
    send_bytes(rb);
    @(negedge clk);
    chk("idle_drop", drop_count, d0 + 16'd3);
    chk("idle_no_rsp", rsp_cnt, c0 + 1);

    // Garbage ahead of SOF while waiting.
    do_cmd(1'b0, 32'h0000_2000, '0, 1'b0);
    d0 = drop_count;
    rb = '{8'h11, 8'h22};
    send_bytes(rb);
    make_reply(8'h00, 8'h10, 1'b1, 32'h1234_5678, 1'b0, rb);
    do_reply(1'b0, rb);
    chk("garbage_drop", drop_count, d0 + 16'd2);

    // Randomized transactions.
    for (int k = 0; k < 6; k++) begin
      wr      = 1'($urandom_range(0, 1));
      a       = $urandom;
      d       = $urandom;
      st      = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      echo    = (wr ? 8'h20 : 8'h10);
      if ($urandom_range(0, 5) == 0) echo = wr ? 8'h10 : 8'h20;
      corrupt = ($urandom_range(0, 3) == 0);
      do_cmd(wr, a, d, 1'b1);
      make_reply(st, echo, (echo == 8'h10 && st == 8'h00), $urandom, corrupt, rb);
      do_reply(wr, rb);
    end
    chk("tx_stall_stability", stab_err, 0);

    // Asynchronous reset during the data phase of a read response.
    do_cmd(1'b0, 32'h0000_1020, '0, 1'b0);
    rb = '{8'h5A, 8'h00, 8'h10, 8'hEF, 8'hBE};
    send_bytes(rb);
    chk("mid_frame_busy", busy, 1);
    c0 = rsp_cnt;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", cmd_ready, 1);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_drop", drop_count, 0);
    repeat (5) @(negedge clk);
    chk("post_reset_no_rsp", rsp_cnt, c0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
